// File: rtl/result_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module   : result_bcd_converter
// Purpose  : Iterative binary-to-BCD converter (shift-and-add-3). It converts
//            one operand bit per clock, driven by a start/busy handshake, and
//            presents packed BCD digits with a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module result_bcd_converter #(
   parameter int DATA_WIDTH = 24,
   parameter int DIGITS     = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic [DATA_WIDTH-1:0]   bin_bi,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [4*DIGITS-1:0]     bcd_bo
);

   // Counter width must be able to hold the value DATA_WIDTH itself.
   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam int CAT_W = 4*DIGITS + DATA_WIDTH;

   localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(DATA_WIDTH);
   localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t                  r_state;
   logic [DATA_WIDTH-1:0]   r_bin_sr;
   logic [4*DIGITS-1:0]     r_bcd_sr;
   logic [CNT_W-1:0]        r_cnt;

   logic [4*DIGITS-1:0]     w_bcd_corr;
   logic [CAT_W-1:0]        w_cat;
   logic [4*DIGITS-1:0]     w_bcd_next;
   logic [DATA_WIDTH-1:0]   w_bin_next;

   // Per-digit add-3 correction: a nibble of 5..9 becomes 8..12, so no carry
   // ever leaves a nibble and the digits can be corrected independently.
   generate
      for (genvar i = 0; i < DIGITS; i++) begin : g_digit
         assign w_bcd_corr[4*i +: 4] = (r_bcd_sr[4*i +: 4] >= 4'd5)
                                       ? (r_bcd_sr[4*i +: 4] + 4'd3)
                                       : r_bcd_sr[4*i +: 4];
      end
   endgenerate

   // One shift of the combined {bcd, bin} register; the operand MSB moves into
   // the BCD LSB and the discarded top bit is always zero for legal sizes.
   assign w_cat      = {w_bcd_corr, r_bin_sr} << 1;
   assign w_bcd_next = w_cat[CAT_W-1:DATA_WIDTH];
   assign w_bin_next = w_cat[DATA_WIDTH-1:0];

   // Control FSM, shift registers and registered outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state  <= S_IDLE;
         r_bin_sr <= '0;
         r_bcd_sr <= '0;
         r_cnt    <= '0;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
         bcd_bo   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               done_o <= 1'b0;
               if (start_i) begin
                  r_bin_sr <= bin_bi;
                  r_bcd_sr <= '0;
                  r_cnt    <= c_cnt_init;
                  busy_o   <= 1'b1;
                  r_state  <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               r_bin_sr <= w_bin_next;
               r_bcd_sr <= w_bcd_next;
               r_cnt    <= r_cnt - c_cnt_one;
               // Last bit: publish the result and hand control back.
               if (r_cnt == c_cnt_one) begin
                  bcd_bo  <= w_bcd_next;
                  done_o  <= 1'b1;
                  busy_o  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               busy_o  <= 1'b0;
               done_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_result_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_bcd_converter
// Purpose  : Scoreboard bench for result_bcd_converter. The driver pushes the
//            expected decimal rendering of each accepted operand; a monitor
//            pops and compares on every done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_bcd_converter;

   localparam int DATA_WIDTH = 24;
   localparam int DIGITS     = 8;
   localparam int LATENCY    = DATA_WIDTH;

   logic                  clk_i = 1'b0;
   logic                  rst_i;
   logic                  start_i;
   logic [DATA_WIDTH-1:0] bin_bi;
   logic                  busy_o;
   logic                  done_o;
   logic [4*DIGITS-1:0]   bcd_bo;

   typedef struct {
      logic [31:0] bcd;
      int          acc;
      logic [23:0] bin;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   logic [31:0] last_bcd  = '0;
   int          busy_run  = 0;
   logic        prev_done = 1'b0;

   result_bcd_converter #(
      .DATA_WIDTH (DATA_WIDTH),
      .DIGITS     (DIGITS)
   ) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (start_i),
      .bin_bi  (bin_bi),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .bcd_bo  (bcd_bo)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   // Reference model: decimal digits by repeated division.
   function automatic logic [31:0] to_bcd(input int unsigned v);
      logic [31:0] r;
      int unsigned x;
      r = '0;
      x = v;
      for (int d = 0; d < DIGITS; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called at a falling edge; holds start until the DUT is idle, then
   // records the expected result for the accepting edge. Returns one falling
   // edge after acceptance with start still asserted.
   task automatic send(input logic [23:0] v);
      int guard;
      guard   = 0;
      bin_bi  = v;
      start_i = 1'b1;
      while (busy_o === 1'b1 && guard < 100) begin
         @(negedge clk_i);
         guard++;
      end
      if (guard >= 100) begin
         chk("accept_timeout", 32'(guard), 32'd0);
      end else begin
         sb.push_back('{bcd: to_bcd(int'(v)), acc: cyc + 1, bin: v});
      end
      @(negedge clk_i);
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while ((sb.size() != 0 || busy_o === 1'b1) && guard < 400) begin
         @(negedge clk_i);
         guard++;
      end
      if (guard >= 400) chk("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   // Monitor: compares results, latency, busy length, pulse width and hold.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_i);
         #1;
         if (rst_i) begin
            last_bcd  = '0;
            busy_run  = 0;
            prev_done = 1'b0;
         end else begin
            if (done_o) begin
               if (sb.size() == 0) begin
                  chk("unexpected_done", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("bcd_result", bcd_bo, e.bcd);
                  chk("latency", 32'(cyc - e.acc), 32'(LATENCY));
                  chk("busy_length", 32'(busy_run), 32'(LATENCY));
                  chk("busy_at_done", {31'd0, busy_o}, 32'd0);
               end
               chk("done_width", {31'd0, prev_done}, 32'd0);
               last_bcd = bcd_bo;
            end else begin
               chk("bcd_hold", bcd_bo, last_bcd);
            end
            busy_run  = busy_o ? busy_run + 1 : 0;
            prev_done = done_o;
         end
      end
   end

   initial begin
      logic [23:0] v;
      rst_i   = 1'b1;
      start_i = 1'b0;
      bin_bi  = '0;
      repeat (3) @(negedge clk_i);
      chk("reset_busy", {31'd0, busy_o}, 32'd0);
      chk("reset_done", {31'd0, done_o}, 32'd0);
      chk("reset_bcd", bcd_bo, 32'd0);
      rst_i = 1'b0;
      @(negedge clk_i);

      // Zero, full scale, back-to-back with start held, add-3 heavy value.
      send(24'd0);        start_i = 1'b0; wait_idle();
      send(24'd16777215); start_i = 1'b0; wait_idle();
      send(24'd1234567);
      send(24'd5535);     start_i = 1'b0; wait_idle();
      send(24'd999);      start_i = 1'b0; wait_idle();

      // Stray start pulses mid-conversion with a changed operand are ignored.
      send(24'd42);
      start_i = 1'b0;
      bin_bi  = 24'd7;
      repeat (3) @(negedge clk_i);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (14) @(negedge clk_i);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      wait_idle();
      repeat (10) @(negedge clk_i);

      // Asynchronous reset mid-conversion aborts without a done pulse.
      send(24'd777);
      start_i = 1'b0;
      repeat (9) @(negedge clk_i);
      #2 rst_i = 1'b1;
      #1;
      chk("async_rst_busy", {31'd0, busy_o}, 32'd0);
      chk("async_rst_done", {31'd0, done_o}, 32'd0);
      chk("async_rst_bcd", bcd_bo, 32'd0);
      sb.delete();
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      repeat (30) @(negedge clk_i);
      send(24'd777); start_i = 1'b0; wait_idle();

      // Randomized operands, sometimes back-to-back, sometimes with gaps.
      for (int n = 0; n < 20; n++) begin
         v = 24'($urandom_range(0, 24'hFFFFFF));
         send(v);
         if ($urandom_range(0, 1) == 1) begin
            start_i = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
         end
      end
      start_i = 1'b0;
      wait_idle();
      repeat (5) @(negedge clk_i);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/result_bcd_converter.md
# result_bcd_converter

Iterative binary-to-BCD converter (shift-and-add-3, "double dabble") that sits directly downstream of the arithmetic unit `main_function`. It takes the unsigned 24-bit `result_bo` word and produces 8 packed BCD digits for the board's display driver. It uses the same `start_i`/`busy_o` handshake as the upstream unit. Conversion processes one bit per clock.

## Interface
- `DATA_WIDTH`, 24: binary input width. Matches the upstream result width.
- `DIGITS`, 8: number of BCD output digits. `10^DIGITS` must exceed `2^DATA_WIDTH - 1`.
- `clk_i`, input, 1: clock; all state updates on the rising edge.
- `rst_i`, input, 1: reset. One clock; reset is asynchronous and active-high.
- `start_i`, input, 1: conversion request. Sampled on the rising edge only while `busy_o` = 0.
- `bin_bi`, input, `DATA_WIDTH`: unsigned binary operand. Captured on the accepting edge.
- `busy_o`, output, 1: high while a conversion is in progress.
- `done_o`, output, 1: one-cycle pulse when `bcd_bo` has just been updated.
- `bcd_bo`, output, `4*DIGITS`: packed BCD result. Digit `i` occupies bits `[4i+3:4i]`; digit 0 is the least significant.

## Operation
- Two-state FSM: IDLE and SHIFT.
- Internal registers:
  - `bin_sr` (`DATA_WIDTH` bits): operand shift register.
  - `bcd_sr` (`4*DIGITS` bits): BCD accumulator.
  - `cnt`: bit counter sized to hold `DATA_WIDTH`.
- IDLE:
  - If `start_i` = 1 at an edge, then on that edge: `bin_sr` <= `bin_bi`, `bcd_sr` <= 0, `cnt` <= `DATA_WIDTH`, `busy_o` <= 1, go to SHIFT.
  - Otherwise hold.
- SHIFT, each edge:
  - Every nibble of `bcd_sr` that is ≥ 5 gets +3. This correction is combinational, applied before the shift.
  - Shift `{corrected bcd_sr, bin_sr}` left by one. The MSB of `bin_sr` enters the LSB of `bcd_sr`.
  - `cnt` <= `cnt` − 1.
- Completion, on the edge where `cnt` = 1 (the last shift):
  - `bcd_bo` <= final shifted value.
  - `done_o` <= 1 and `busy_o` <= 0; return to IDLE.
  - On the following edge `done_o` <= 0.
- `bcd_bo` holds the last completed result until the next completion. It is not cleared at start.
- `start_i` while `busy_o` = 1 is ignored, including on the completion edge. No queuing.
- `bin_bi` changes after the accepting edge have no effect.
- Arithmetic: corrected nibbles never exceed 4'd12 before the shift, so no digit carries across a nibble during correction. Every 24-bit input fits in 8 digits, so there is no overflow case.

## Timing
- Reset, applied asynchronously and held while `rst_i` = 1:
  - FSM = IDLE.
  - `busy_o` = 0, `done_o` = 0, `bcd_bo` = 0.
  - `bin_sr`, `bcd_sr` and `cnt` = 0.
- Reset mid-conversion aborts the conversion. No `done_o` pulse is produced, and the first `start_i` after reset release starts a fresh conversion.
- Latency:
  - Start accepted at edge E.
  - `busy_o` is high after edges E through E+`DATA_WIDTH`−1.
  - The result and the `done_o` pulse appear after edge E+`DATA_WIDTH` (E+24 by default).
  - `busy_o` falls at that same edge.
- Throughput: a new `start_i` is accepted at edge E+`DATA_WIDTH`+1 at the earliest. That gives one conversion per 25 cycles back-to-back.
- Upstream coupling: the integrating logic drives `start_i` from the falling edge of the upstream `busy_o`, with `bin_bi` = upstream `result_bo`. The upstream result is stable while the upstream unit is idle, so no input register is needed outside this block.

## Test plan
- Reset, then `start_i` = 1 for one cycle with `bin_bi` = 24'd0:
  - `busy_o` is high for 24 cycles.
  - Then `done_o` pulses for one cycle with `bcd_bo` = 32'h00000000.
- `bin_bi` = 24'd16777215 (max value) → `bcd_bo` = 32'h16777215 exactly 24 edges after acceptance.
- `bin_bi` = 24'd1234567 → 32'h01234567. Then immediately `bin_bi` = 24'd5535 with `start_i` held high:
  - The second conversion is accepted at the first edge after `busy_o` falls.
  - It completes with `bcd_bo` = 32'h00005535.
  - 32'h01234567 stays on `bcd_bo` until then.
- `bin_bi` = 24'd999 → 32'h00000999. This exercises the add-3 correction on every low digit.
- Pulse `start_i` at cycles 5 and 20 of a running conversion (`bin_bi` = 24'd42), with `bin_bi` changed to 24'd7 meanwhile:
  - Both pulses are ignored.
  - The result is 32'h00000042, and exactly one `done_o` pulse is produced.
- Assert `rst_i` at cycle 10 of a conversion of 24'd777:
  - `busy_o`, `done_o` and `bcd_bo` go to 0 immediately, without waiting for a clock edge.
  - No `done_o` pulse follows.
  - A fresh conversion of 24'd777 after reset release yields 32'h00000777.
